alarm_setter: RTL

Button-driven editor that lets the user enter a new mm:ss alarm time one BCD digit at a time and commits it to the alarm register stage. It sits directly upstream of the alarm comparator/register block. It drives that block's load-value bus and its one-cycle load strobe. It also exports edit-state hints (active digit, blink phase) for the 7-segment display mux.

---
 rtl/alarm_setter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alarm_setter.sv
// rtl/alarm_setter.sv - button-driven BCD mm:ss alarm time editor with one-cycle load strobe
// Purpose : lets the user step through min1/min0/sec1/sec0, increment each BCD digit with
//           wrap, and commit the edited time to the downstream alarm register stage.
// Option  : `ALARM_SET_TIMEOUT_EN adds an inactivity abort after TIMEOUT_TICKS ticks.
// Ports   : clk, rst_n (async active-low)
//           tick                       1 Hz enable pulse
//           set_press/inc_press/cancel_press  one-cycle button pulses
//           cur_min1..cur_sec0         currently stored alarm digits (edit start point)
//           load_value_min1..sec0      edit registers, driven continuously
//           load_value_enable          one-cycle commit strobe
//           editing, edit_digit, blink display-mux hints
`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

module alarm_setter #(
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   input  logic                      set_press,
   input  logic                      inc_press,
   input  logic                      cancel_press,
   input  logic [`BCD_BIT_WIDTH-1:0] cur_min1,
   input  logic [`BCD_BIT_WIDTH-1:0] cur_min0,
   input  logic [`BCD_BIT_WIDTH-1:0] cur_sec1,
   input  logic [`BCD_BIT_WIDTH-1:0] cur_sec0,
   output logic [`BCD_BIT_WIDTH-1:0] load_value_min1,
   output logic [`BCD_BIT_WIDTH-1:0] load_value_min0,
   output logic [`BCD_BIT_WIDTH-1:0] load_value_sec1,
   output logic [`BCD_BIT_WIDTH-1:0] load_value_sec0,
   output logic                      load_value_enable,
   output logic                      editing,
   output logic [3:0]                edit_digit,
   output logic                      blink
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      E_MIN1 = 3'd1,
      E_MIN0 = 3'd2,
      E_SEC1 = 3'd3,
      E_SEC0 = 3'd4,
      COMMIT = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [`BCD_BIT_WIDTH-1:0] r_min1, r_min0, r_sec1, r_sec0;
   logic                      r_blink;
   logic                      w_editing;
   logic                      w_next_editing;
   logic                      w_inc_only;
   logic                      w_timeout;

   if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
      $error("alarm_setter: TIMEOUT_TICKS must be >= 1");
   end

   // Digits above their maximum (illegal captured values) fall back to 0.
   function automatic logic [`BCD_BIT_WIDTH-1:0] inc_wrap(
      input logic [`BCD_BIT_WIDTH-1:0] d,
      input logic [`BCD_BIT_WIDTH-1:0] max_val
   );
      return (d >= max_val) ? '0 : d + 1'b1;
   endfunction

   assign w_editing      = (r_state == E_MIN1) || (r_state == E_MIN0) ||
                           (r_state == E_SEC1) || (r_state == E_SEC0);
   assign w_next_editing = (w_next == E_MIN1) || (w_next == E_MIN0) ||
                           (w_next == E_SEC1) || (w_next == E_SEC0);
   // inc only acts when neither cancel nor set claims the cycle.
   assign w_inc_only     = w_editing && inc_press && !set_press && !cancel_press;

`ifdef ALARM_SET_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);
   logic [CW-1:0] r_idle_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_press;

   assign w_press   = set_press | inc_press | cancel_press;
   assign w_cnt_inc = r_idle_cnt + 1'b1;
   // Any press in the same cycle wins over the expiring tick.
   assign w_timeout = w_editing && tick && !w_press && (w_cnt_inc == CW'(TIMEOUT_TICKS));

   // Held at zero outside edit states, so every session starts from a clean count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if (!w_editing || w_press || w_timeout) begin
         r_idle_cnt <= '0;
      end else if (tick) begin
         r_idle_cnt <= w_cnt_inc;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (set_press) w_next = E_MIN1;
         E_MIN1:  if (cancel_press || w_timeout) w_next = IDLE;
                  else if (set_press)            w_next = E_MIN0;
         E_MIN0:  if (cancel_press || w_timeout) w_next = IDLE;
                  else if (set_press)            w_next = E_SEC1;
         E_SEC1:  if (cancel_press || w_timeout) w_next = IDLE;
                  else if (set_press)            w_next = E_SEC0;
         E_SEC0:  if (cancel_press || w_timeout) w_next = IDLE;
                  else if (set_press)            w_next = COMMIT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min1 <= '0;
         r_min0 <= '0;
         r_sec1 <= '0;
         r_sec0 <= '0;
      end else if (r_state == IDLE && set_press) begin
         r_min1 <= cur_min1;
         r_min0 <= cur_min0;
         r_sec1 <= cur_sec1;
         r_sec0 <= cur_sec0;
      end else if (w_inc_only) begin
         case (r_state)
            E_MIN1:  r_min1 <= inc_wrap(r_min1, `BCD_BIT_WIDTH'(5));
            E_MIN0:  r_min0 <= inc_wrap(r_min0, `BCD_BIT_WIDTH'(9));
            E_SEC1:  r_sec1 <= inc_wrap(r_sec1, `BCD_BIT_WIDTH'(5));
            E_SEC0:  r_sec0 <= inc_wrap(r_sec0, `BCD_BIT_WIDTH'(9));
            default: ;
         endcase
      end
   end

   // Blink starts high on session entry and free-runs on tick; digit advance keeps phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink <= 1'b0;
      end else if (!w_next_editing) begin
         r_blink <= 1'b0;
      end else if (r_state == IDLE) begin
         r_blink <= 1'b1;
      end else if (tick) begin
         r_blink <= ~r_blink;
      end
   end

   assign load_value_min1   = r_min1;
   assign load_value_min0   = r_min0;
   assign load_value_sec1   = r_sec1;
   assign load_value_sec0   = r_sec0;
   assign load_value_enable = (r_state == COMMIT);
   assign editing           = w_editing;
   assign edit_digit        = {r_state == E_MIN1, r_state == E_MIN0,
                               r_state == E_SEC1, r_state == E_SEC0};
   assign blink             = r_blink;

endmodule
